// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8 -- round-robin arbiter sharing one resource among 8 requesters.
//
// A requester keeps the grant for as long as it holds its request (no
// preemption). On release, priority rotates to the requester after the one
// just served. Every release costs exactly one idle cycle before the next
// grant is issued.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   en           arbitration enable; gates new grants only, never an existing one
//   req[7:0]     request vector; req[i] high = requester i wants/holds the resource
//   grant[7:0]   registered one-hot grant, zero when idle
//   grant_idx    binary index of the granted requester, zero when idle
//   grant_valid  high whenever grant is non-zero
//
// Parameters:
//   MAX_HOLD     maximum consecutive grant cycles (1..255), timeout build only
//   HOLD_W       width of the hold timer, must be able to hold MAX_HOLD-1
//
// Build option:
//   ARB_TIMEOUT_EN  when defined, a holder that still requests is forcibly
//                   released after MAX_HOLD grant cycles. When undefined, no
//                   hold timer is built and MAX_HOLD/HOLD_W are unused.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no grant outstanding; next edge may issue one if en && req
// GRANT | grant_idx owns the resource until its request drops (or timeout)

module rr_arbiter_8 #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [2:0] ptr;

  // Rotated view of req: req_rot[k] is req[(ptr + k) mod 8], so the lowest set
  // bit of req_rot is the winner and its offset is added back to ptr.
  logic [15:0] req_dbl;
  logic [7:0]  req_rot;
  logic [2:0]  pick_off;
  logic [2:0]  pick_idx;
  logic        pick_any;

  always_comb begin
    req_dbl  = {req, req};
    req_rot  = req_dbl[ptr +: 8];
    pick_off = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (req_rot[k]) pick_off = 3'(k);
    end
    pick_idx = ptr + pick_off;
    pick_any = |req;
  end

  logic timeout;

`ifdef ARB_TIMEOUT_EN
  // Down-counter of grant cycles remaining after the current one; loaded with
  // MAX_HOLD-1 when a grant is issued, terminal count zero forces release.
  logic [HOLD_W-1:0] hold_cnt;

  assign timeout = (hold_cnt == '0);
`else
  logic unused_params;

  assign timeout       = 1'b0;
  assign unused_params = ^{32'(MAX_HOLD), 32'(HOLD_W)};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= 8'h00;
      grant_idx   <= 3'd0;
      grant_valid <= 1'b0;
      ptr         <= 3'd0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (en && pick_any) begin
            state       <= GRANT;
            grant       <= 8'(1) << pick_idx;
            grant_idx   <= pick_idx;
            grant_valid <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            hold_cnt    <= HOLD_W'(MAX_HOLD - 1);
`endif
          end
        end
        GRANT: begin
          // Voluntary and forced releases share one path so both advance the
          // pointer and both insert the single idle bubble.
          if (!req[grant_idx] || timeout) begin
            state       <= IDLE;
            grant       <= 8'h00;
            grant_idx   <= 3'd0;
            grant_valid <= 1'b0;
            ptr         <= grant_idx + 3'd1;
          end else begin
`ifdef ARB_TIMEOUT_EN
            hold_cnt    <= hold_cnt - HOLD_W'(1);
`endif
          end
        end
        default: begin
          state       <= IDLE;
          grant       <= 8'h00;
          grant_idx   <= 3'd0;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
module tb_rr_arbiter_8;

  localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;

  rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD), .HOLD_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req        (req),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] idx;
    logic       valid;
  } vec_t;

  typedef struct {
    logic [7:0] grant;
    logic [2:0] idx;
    logic       valid;
    string      name;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Independent reference model for the random phase.
  logic       m_busy;
  logic [2:0] m_ptr;
  logic [2:0] m_idx;
  int         m_held;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic v(input logic r, input logic e, input logic [7:0] q,
                   input logic [7:0] g, input logic [2:0] i, input logic val);
    tbl.push_back('{r, e, q, g, i, val});
  endtask

  // Drive one cycle of inputs, queue the expected outputs, then compare what
  // the DUT registered on that edge.
  task automatic apply(input logic r, input logic e, input logic [7:0] q,
                       input logic [7:0] g, input logic [2:0] i, input logic val,
                       input string nm);
    exp_t x;
    @(negedge clk);
    rst = r;
    en  = e;
    req = q;
    x.grant = g;
    x.idx   = i;
    x.valid = val;
    x.name  = nm;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({x.name, ".grant"}, 32'(grant), 32'(x.grant));
    chk({x.name, ".idx"}, 32'(grant_idx), 32'(x.idx));
    chk({x.name, ".valid"}, 32'(grant_valid), 32'(x.valid));
    chk({x.name, ".onehot0"}, 32'($onehot0(grant)), 32'd1);
  endtask

  task automatic model_step(input logic r, input logic e, input logic [7:0] q,
                            output logic [7:0] g, output logic [2:0] i, output logic val);
    if (r) begin
      m_busy = 1'b0;
      m_ptr  = 3'd0;
      m_idx  = 3'd0;
      m_held = 0;
    end else if (!m_busy) begin
      if (e && q != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          int j;
          j = (int'(m_ptr) + k) % 8;
          if (q[j] && !m_busy) begin
            m_busy = 1'b1;
            m_idx  = 3'(j);
            m_held = 1;
          end
        end
      end
    end else begin
      if (!q[m_idx] || (TIMEOUT_ON && m_held == MAX_HOLD)) begin
        m_busy = 1'b0;
        m_ptr  = m_idx + 3'd1;
      end else begin
        m_held++;
      end
    end
    g   = m_busy ? (8'd1 << m_idx) : 8'd0;
    i   = m_busy ? m_idx : 3'd0;
    val = m_busy;
  endtask

  initial begin
    // reset / idle, then first grant from ptr 0
    v(1, 1, 8'hFF, 8'h00, 0, 0);
    v(1, 1, 8'hFF, 8'h00, 0, 0);
    v(0, 1, 8'hFF, 8'h01, 0, 1);
    v(0, 1, 8'h00, 8'h00, 0, 0);   // release, ptr=1
    v(0, 1, 8'h00, 8'h00, 0, 0);
    // basic rotation
    v(1, 1, 8'h00, 8'h00, 0, 0);   // ptr=0
    v(0, 1, 8'h05, 8'h01, 0, 1);
    v(0, 1, 8'h05, 8'h01, 0, 1);
    v(0, 1, 8'h04, 8'h00, 0, 0);   // bubble, ptr=1
    v(0, 1, 8'h04, 8'h04, 2, 1);
    v(0, 1, 8'h00, 8'h00, 0, 0);   // ptr=3
    // wrap-around: get ptr to 7
    v(0, 1, 8'h40, 8'h40, 6, 1);
    v(0, 1, 8'h81, 8'h00, 0, 0);   // release wins over new requests, ptr=7
    v(0, 1, 8'h81, 8'h80, 7, 1);
    v(0, 1, 8'h81, 8'h80, 7, 1);
    v(0, 1, 8'h01, 8'h00, 0, 0);   // ptr wraps to 0
    v(0, 1, 8'h01, 8'h01, 0, 1);
    v(0, 1, 8'h00, 8'h00, 0, 0);   // ptr=1
    // enable gating
    for (int c = 0; c < 5; c++) v(0, 0, 8'h10, 8'h00, 0, 0);
    v(0, 1, 8'h10, 8'h10, 4, 1);
    v(0, 0, 8'h10, 8'h10, 4, 1);
    v(0, 0, 8'h10, 8'h10, 4, 1);
    v(0, 0, 8'h00, 8'h00, 0, 0);   // ptr=5
    v(0, 0, 8'hFF, 8'h00, 0, 0);
    v(0, 1, 8'hFF, 8'h20, 5, 1);
    v(0, 1, 8'h00, 8'h00, 0, 0);   // ptr=6
    // no preemption
    v(0, 1, 8'h02, 8'h02, 1, 1);
    v(0, 1, 8'hFF, 8'h02, 1, 1);
    v(0, 1, 8'hFD, 8'h00, 0, 0);   // ptr=2
    v(0, 1, 8'hFD, 8'h04, 2, 1);
    v(0, 1, 8'h00, 8'h00, 0, 0);   // ptr=3
    // reset mid-grant
    v(0, 1, 8'h08, 8'h08, 3, 1);
    v(1, 1, 8'h08, 8'h00, 0, 0);
    v(0, 1, 8'h08, 8'h08, 3, 1);
    v(0, 1, 8'h00, 8'h00, 0, 0);   // ptr=4
    v(0, 1, 8'h21, 8'h20, 5, 1);
    v(1, 1, 8'h21, 8'h00, 0, 0);   // ptr back to 0
    v(0, 1, 8'h21, 8'h01, 0, 1);
    v(0, 1, 8'h00, 8'h00, 0, 0);
    v(0, 1, 8'h00, 8'h00, 0, 0);

    foreach (tbl[n])
      apply(tbl[n].rst, tbl[n].en, tbl[n].req, tbl[n].grant, tbl[n].idx, tbl[n].valid,
            $sformatf("vec%0d", n));

    // Constant two-way contention: timeout alternates owners, otherwise idx0 holds.
    apply(1, 1, 8'h81, 8'h00, 0, 0, "to_rst");
    for (int c = 1; c <= 11; c++) begin
      logic [7:0] g;
      logic [2:0] i;
      logic       val;
      if (!TIMEOUT_ON || c <= 4 || c == 11) begin
        g = 8'h01; i = 3'd0; val = 1'b1;
      end else if (c == 5 || c == 10) begin
        g = 8'h00; i = 3'd0; val = 1'b0;
      end else begin
        g = 8'h80; i = 3'd7; val = 1'b1;
      end
      apply(0, 1, 8'h81, g, i, val, $sformatf("timeout_c%0d", c));
    end

    // Random traffic against the reference model.
    begin
      logic [7:0] g;
      logic [2:0] i;
      logic       val;
      logic       r;
      logic       e;
      logic [7:0] q;
      model_step(1'b1, 1'b0, 8'h00, g, i, val);
      apply(1'b1, 1'b0, 8'h00, g, i, val, "rand_rst");
      for (int c = 0; c < 400; c++) begin
        r = ($urandom_range(0, 63) == 0);
        e = ($urandom_range(0, 3) != 0);
        q = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
        model_step(r, e, q, g, i, val);
        apply(r, e, q, g, i, val, $sformatf("rand%0d", c));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
